// File: rtl/fp8_pkg.sv
// fp8_pkg: field layout and FSM states shared by the fp8 converter and adder.
// Word layout {sign, exp[2:0], frac[3:0]}.
package fp8_pkg;

  localparam int SIGN_BIT     = 7;
  localparam int EXP_MSB      = 6;
  localparam int EXP_LSB      = 4;
  localparam int FRAC_W       = 4;
  localparam int EXP_W        = 3;
  localparam int DEFAULT_BIAS = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/fp8_unpack.sv
// fp8_unpack: splits an fp8 word into sign, exponent and hidden-one mantissa.
// Purely combinational; shared with the float adder.
module fp8_unpack
  import fp8_pkg::*;
(
  input  logic [7:0]        fp_in,
  output logic              is_zero,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W:0]   mant
);

  assign is_zero = (fp_in[EXP_MSB:0] == '0);
  assign sign    = fp_in[SIGN_BIT];
  assign exp     = fp_in[EXP_MSB:EXP_LSB];
  assign mant    = {1'b1, fp_in[FRAC_W-1:0]};

endmodule

// File: rtl/fp8_to_fixed.sv
// fp8_to_fixed: iterative fp8 -> signed fixed-point, one shift per clock.
// FP8_DEC_SAT_EN adds an ovf port and saturates instead of wrapping.
module fp8_to_fixed
  import fp8_pkg::*;
#(
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 8,
  parameter int BIAS      = DEFAULT_BIAS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       fp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] fix_out
`ifdef FP8_DEC_SAT_EN
  ,
  output logic             ovf
`endif
);

  localparam int MAG_W = FRAC_BITS - BIAS + 8;
  localparam int SH    = FRAC_BITS - FRAC_W - BIAS;

  if (FRAC_BITS < BIAS + 4) begin : g_bad_frac
    $error("FRAC_BITS must be >= BIAS+4");
  end

  state_t           state, state_n;
  logic [MAG_W-1:0] mag, mag_n;
  logic [EXP_W-1:0] cnt, cnt_n;
  logic             sign, sign_n;
  logic [OUT_W-1:0] fix_n;
  logic             ov_n;
  logic [OUT_W-1:0] res;

  logic             u_zero;
  logic             u_sign;
  logic [EXP_W-1:0] u_exp;
  logic [FRAC_W:0]  u_mant;

  fp8_unpack u_unpack (
    .fp_in   (fp_in),
    .is_zero (u_zero),
    .sign    (u_sign),
    .exp     (u_exp),
    .mant    (u_mant)
  );

  assign in_ready = (state == IDLE);

`ifdef FP8_DEC_SAT_EN
  localparam int W = MAG_W + OUT_W;
  localparam logic [W-1:0] SAT_MAX =
    W'((64'd1 << (OUT_W - 1)) - 64'd1);

  logic             big;
  logic             ovf_n;
  logic [OUT_W-1:0] mag_o;

  always_comb begin
    mag_o = OUT_W'(mag);
    big   = (W'(mag) > SAT_MAX);
    if (big) mag_o = OUT_W'(SAT_MAX);
    res   = sign ? -mag_o : mag_o;
  end
`else
  logic [OUT_W-1:0] mag_o;

  // Truncation commutes with negation, so wrapping is just the low bits.
  always_comb begin
    mag_o = OUT_W'(mag);
    res   = sign ? -mag_o : mag_o;
  end
`endif

  always_comb begin
    state_n = state;
    mag_n   = mag;
    cnt_n   = cnt;
    sign_n  = sign;
    fix_n   = fix_out;
    ov_n    = out_valid;
`ifdef FP8_DEC_SAT_EN
    ovf_n   = ovf;
`endif
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = SHIFT;
          if (u_zero) begin
            mag_n  = '0;
            cnt_n  = '0;
            sign_n = 1'b0;
          end else begin
            mag_n  = {{(MAG_W-FRAC_W-1){1'b0}}, u_mant} << SH;
            cnt_n  = u_exp;
            sign_n = u_sign;
          end
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          mag_n = mag << 1;
          cnt_n = cnt - 1'b1;
        end else begin
          fix_n   = res;
          ov_n    = 1'b1;
          state_n = DONE;
`ifdef FP8_DEC_SAT_EN
          ovf_n   = big;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mag       <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      fix_out   <= '0;
      out_valid <= 1'b0;
`ifdef FP8_DEC_SAT_EN
      ovf       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      mag       <= mag_n;
      cnt       <= cnt_n;
      sign      <= sign_n;
      fix_out   <= fix_n;
      out_valid <= ov_n;
`ifdef FP8_DEC_SAT_EN
      ovf       <= ovf_n;
`endif
    end
  end

endmodule

// File: tb/tb_fp8_to_fixed.sv
// tb_fp8_to_fixed: directed and random conversions against an arithmetic model.
// Builds with or without FP8_DEC_SAT_EN (OUT_W=12 when enabled).
module tb_fp8_to_fixed;

`ifdef FP8_DEC_SAT_EN
  localparam int OUT_W = 12;
`else
  localparam int OUT_W = 16;
`endif
  localparam int FRAC_BITS = 8;
  localparam int BIAS      = 3;

  logic             clk = 0;
  logic             rst_n = 0;
  logic             in_valid = 0;
  logic             in_ready;
  logic [7:0]       fp_in = '0;
  logic             out_valid;
  logic             out_ready = 0;
  logic [OUT_W-1:0] fix_out;
  logic             ovf_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp8_to_fixed #(
    .OUT_W     (OUT_W),
    .FRAC_BITS (FRAC_BITS),
    .BIAS      (BIAS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fix_out   (fix_out)
`ifdef FP8_DEC_SAT_EN
    ,
    .ovf       (ovf_w)
`endif
  );

`ifndef FP8_DEC_SAT_EN
  assign ovf_w = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // value = 1.frac * 2^(exp-BIAS), scaled by 2^FRAC_BITS
  function automatic logic [OUT_W-1:0] model(input logic [7:0] f,
                                             output logic ov);
    longint v;
    longint lim;
    ov  = 1'b0;
    lim = (longint'(1) << (OUT_W - 1)) - 1;
    if (f[6:0] == 7'd0) v = 0;
    else v = ((16 + longint'(f[3:0])) * (longint'(1) << f[6:4])
              * (longint'(1) << FRAC_BITS)) / (longint'(1) << (4 + BIAS));
`ifdef FP8_DEC_SAT_EN
    if (v > lim) begin
      v  = lim;
      ov = 1'b1;
    end
`endif
    if (f[7] && v != 0) v = -v;
    return OUT_W'(v);
  endfunction

  logic [OUT_W-1:0] last_fix;

  task automatic accept(input logic [7:0] f);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    fp_in    = f;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic collect(input logic [7:0] f, input int stall);
    int lat = 0;
    logic [OUT_W-1:0] e;
    logic eo;
    e = model(f, eo);
    while (!out_valid && lat < 20) begin
      lat++;
      if (lat > 1 || !out_valid) begin
        @(posedge clk); #1;
      end
    end
    check("latency", lat, (f[6:0] == 0) ? 32'd1 : 32'(f[6:4]) + 32'd1);
    check("fix_out", 32'(fix_out), 32'(e));
`ifdef FP8_DEC_SAT_EN
    check("ovf", {31'd0, ovf_w}, {31'd0, eo});
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_fix", 32'(fix_out), 32'(e));
      check("stall_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("drop_valid", {31'd0, out_valid}, 32'd0);
    check("retain_fix", 32'(fix_out), 32'(e));
    last_fix = e;
  endtask

  task automatic conv(input logic [7:0] f, input int stall);
    accept(f);
    collect(f, stall);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_fix", 32'(fix_out), 32'd0);
    check("rst_ovf", {31'd0, ovf_w}, 32'd0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    conv(8'h38, 0);
`ifndef FP8_DEC_SAT_EN
    check("c_1p5", 32'(last_fix), 32'h0180);
`endif
    conv(8'hB8, 0);
`ifndef FP8_DEC_SAT_EN
    check("c_m1p5", 32'(last_fix), 32'hFE80);
`endif
    conv(8'h01, 0);
`ifndef FP8_DEC_SAT_EN
    check("c_01", 32'(last_fix), 32'h0022);
`endif
    conv(8'h7F, 0);
`ifndef FP8_DEC_SAT_EN
    check("c_31", 32'(last_fix), 32'h1F00);
`endif
    conv(8'h00, 0);
    check("c_pz", 32'(last_fix), 32'h0);
    conv(8'h80, 0);
    check("c_nz", 32'(last_fix), 32'h0);
    conv(8'h38, 5);
`ifdef FP8_DEC_SAT_EN
    conv(8'hFF, 0);
    check("c_sat", 32'(last_fix), 32'h801);
`endif

    // out_ready and in_valid together in DONE: upstream word waits a cycle
    accept(8'h25);
    while (!out_valid) begin
      @(posedge clk); #1;
    end
    fp_in     = 8'h41;
    in_valid  = 1;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("same_cyc_valid", {31'd0, out_valid}, 32'd0);
    check("same_cyc_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
    check("same_cyc_acc", {31'd0, in_ready}, 32'd0);
    collect(8'h41, 0);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] r;
      r = 8'($urandom);
      conv(r, int'($urandom_range(0, 3)));
    end

    // async reset mid-conversion
    accept(8'h7F);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_fix", 32'(fix_out), 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_ovf", {31'd0, ovf_w}, 32'd0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end
    conv(8'h5A, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
